// File: rtl/viterbi_pkg.sv
// Constants and types shared by conv_encoder and viterbi_decoder (K=3, rate 1/2, octal 7/5).
package viterbi_pkg;

  localparam int K      = 3;
  localparam int MSG_W  = 8;
  localparam int CODE_W = 16;
  localparam int CNT_W  = $clog2(MSG_W);

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // Trellis state {s1,s2}: s1 is the previous input bit, s2 the one before it.
  typedef logic [K-2:0] enc_st_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_DONE   = 2'd2
  } enc_fsm_e;

endpackage

// File: rtl/conv_enc_step.sv
// One trellis step of the 7/5 encoder: coded pair {c0,c1} and next state for input bit u.
module conv_enc_step
  import viterbi_pkg::*;
(
  input  logic    u,
  input  enc_st_t i_st,
  output logic [1:0] o_pair,
  output enc_st_t o_next_st
);

  logic [K-1:0] w_win;

  // Window ordered {u, s1, s2} so that the generator MSB taps the newest bit.
  assign w_win     = {u, i_st};
  assign o_pair    = {^(w_win & G0), ^(w_win & G1)};
  assign o_next_st = {u, i_st[1]};

endmodule

// File: rtl/conv_encoder.sv
// Bit-serial rate-1/2 K=3 convolutional encoder: 8-bit message in, 16-bit code word out after 10 cycles.
// Optional error injection (i_err_mask port and mask register) with CONV_ENC_ERR_INJECT_EN.
module conv_encoder
  import viterbi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MSG_W-1:0]  i_data,
`ifdef CONV_ENC_ERR_INJECT_EN
  input  logic [CODE_W-1:0] i_err_mask,
`endif
  output logic [CODE_W-1:0] o_data,
  output logic              o_done,
  output logic              o_busy,
  output logic [1:0]        o_dbg_state
);

  // Start handshake: a request is taken when en is high on an edge while IDLE;
  // o_busy low means the next en will be accepted, o_done marks o_data valid.
  enc_fsm_e          r_state;
  enc_fsm_e          w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [MSG_W-1:0]  r_msg_sr;
  enc_st_t           r_enc_st;
  logic [CODE_W-1:0] r_out_sr;
  logic [CODE_W-1:0] r_data;
  logic              r_done;
  logic [1:0]        w_pair;
  enc_st_t           w_next_enc_st;
  logic [CODE_W-1:0] w_mask;

  conv_enc_step u_step (
    .u         (r_msg_sr[MSG_W-1]),
    .i_st      (r_enc_st),
    .o_pair    (w_pair),
    .o_next_st (w_next_enc_st)
  );

`ifdef CONV_ENC_ERR_INJECT_EN
  logic [CODE_W-1:0] r_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
    end else if (r_state == ST_IDLE && en) begin
      r_mask <= i_err_mask;
    end
  end

  assign w_mask = r_mask;
`else
  assign w_mask = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (en) w_next_state = ST_ENCODE;
      ST_ENCODE: if (r_cnt == CNT_W'(MSG_W - 1)) w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = 1'b0;
    o_dbg_state = r_state;
    if (r_state == ST_ENCODE || r_state == ST_DONE) o_busy = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_msg_sr <= '0;
      r_enc_st <= '0;
      r_out_sr <= '0;
      r_data   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_msg_sr <= i_data;
            r_cnt    <= '0;
            r_enc_st <= '0;
            r_out_sr <= '0;
          end
        end
        ST_ENCODE: begin
          // Older pairs drift toward [15:14], so the first pair lands on top.
          r_msg_sr <= {r_msg_sr[MSG_W-2:0], 1'b0};
          r_out_sr <= {r_out_sr[CODE_W-3:0], w_pair};
          r_enc_st <= w_next_enc_st;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          r_data <= r_out_sr ^ w_mask;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_data = r_data;
  assign o_done = r_done;

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: directed table, back-to-back, mid-block reset and random blocks vs a reference model.
module tb_conv_encoder;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  i_data;
  logic [15:0] i_err_mask;
  logic [15:0] o_data;
  logic        o_done;
  logic        o_busy;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  msg;
    logic [15:0] code;
  } vec_t;

  vec_t tbl[4];

  conv_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .i_data      (i_data),
`ifdef CONV_ENC_ERR_INJECT_EN
    .i_err_mask  (i_err_mask),
`endif
    .o_data      (o_data),
    .o_done      (o_done),
    .o_busy      (o_busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Convolution of the message bit stream u[n] with taps 7 and 5; u[-1]=u[-2]=0.
  function automatic logic [15:0] ref_encode(input logic [7:0] msg);
    logic [15:0] code;
    logic        u [0:9];
    code = '0;
    u[0] = 1'b0;
    u[1] = 1'b0;
    for (int i = 0; i < 8; i++) u[i+2] = msg[7-i];
    for (int i = 0; i < 8; i++) begin
      code[15-2*i] = u[i+2] ^ u[i+1] ^ u[i];
      code[14-2*i] = u[i+2] ^ u[i];
    end
    return code;
  endfunction

  function automatic logic [15:0] eff_mask(input logic [15:0] m);
`ifdef CONV_ENC_ERR_INJECT_EN
    return m;
`else
    return 16'h0000 & m;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Starts one block, scrambles inputs after capture, waits (bounded) for o_done.
  task automatic run_block(input logic [7:0] msg, input logic [15:0] mask,
                           output logic [15:0] code, output int lat, output int busy_n);
    @(negedge clk);
    en         = 1'b1;
    i_data     = msg;
    i_err_mask = mask;
    @(posedge clk);
    #1;
    en         = 1'b0;
    i_data     = 8'($urandom);
    i_err_mask = 16'($urandom);
    lat    = 0;
    busy_n = 0;
    while (lat < 20) begin
      if (o_busy) busy_n++;
      @(posedge clk);
      #1;
      lat++;
      if (o_done) break;
    end
    code = o_data;
  endtask

  initial begin
    logic [15:0] code;
    int          lat;
    int          busy_n;
    int          done_at[$];
    logic [15:0] done_data[$];
    int          prev_done;
    int          dbl;
    logic [7:0]  m;
    logic [15:0] mk;

    tbl[0] = '{msg: 8'hB0, code: 16'hE170};
    tbl[1] = '{msg: 8'h80, code: 16'hEC00};
    tbl[2] = '{msg: 8'hFF, code: 16'hDAAA};
    tbl[3] = '{msg: 8'h00, code: 16'h0000};

    rst = 1'b1; en = 1'b0; i_data = 8'h00; i_err_mask = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_o_data", 32'(o_data), 32'h0);
    check("reset_o_done", 32'(o_done), 32'h0);
    check("reset_o_busy", 32'(o_busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table with latency / busy-width checks
    for (int i = 0; i < 4; i++) begin
      run_block(tbl[i].msg, 16'h0000, code, lat, busy_n);
      check($sformatf("tbl%0d_code", i), 32'(code), 32'(tbl[i].code));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd9);
      check($sformatf("tbl%0d_busy_cycles", i), 32'(busy_n), 32'd9);
      check($sformatf("tbl%0d_busy_at_done", i), 32'(o_busy), 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_done_pulse", i), 32'(o_done), 32'h0);
      check($sformatf("tbl%0d_data_hold", i), 32'(o_data), 32'(tbl[i].code));
    end

    // Back-to-back with en held high: B0 then FF
    @(negedge clk);
    en = 1'b1; i_data = 8'hB0; i_err_mask = 16'h0000;
    @(posedge clk);
    #1;
    i_data = 8'hFF;
    prev_done = 0;
    dbl = 0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) i_data = 8'hFF;
      if (k == 10) en = 1'b0;
      if (o_done) begin
        done_at.push_back(k);
        done_data.push_back(o_data);
        if (prev_done != 0) dbl++;
      end
      prev_done = int'(o_done);
    end
    check("b2b_pulse_count", 32'(done_at.size()), 32'd2);
    if (done_at.size() == 2) begin
      check("b2b_first_at", 32'(done_at[0]), 32'd9);
      check("b2b_second_at", 32'(done_at[1]), 32'd19);
      check("b2b_first_data", 32'(done_data[0]), 32'hE170);
      check("b2b_second_data", 32'(done_data[1]), 32'hDAAA);
    end
    check("b2b_no_double_done", 32'(dbl), 32'd0);

    // Reset on the 4th ENCODE edge of an FF block
    @(negedge clk);
    en = 1'b1; i_data = 8'hFF;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_o_data", 32'(o_data), 32'h0);
    check("midrst_o_busy", 32'(o_busy), 32'h0);
    check("midrst_o_done", 32'(o_done), 32'h0);
    dbl = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (o_done || o_busy) dbl++;
    end
    check("midrst_no_activity", 32'(dbl), 32'd0);
    run_block(8'h80, 16'h0000, code, lat, busy_n);
    check("after_rst_code", 32'(code), 32'hEC00);
    check("after_rst_latency", 32'(lat), 32'd9);

`ifdef CONV_ENC_ERR_INJECT_EN
    run_block(8'hB0, 16'h8001, code, lat, busy_n);
    check("inject_code", 32'(code), 32'h6171);
`endif

    // Random blocks against the reference model
    for (int i = 0; i < 40; i++) begin
      m  = 8'($urandom_range(0, 255));
      mk = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
      exp_q.push_back(ref_encode(m) ^ eff_mask(mk));
      run_block(m, mk, code, lat, busy_n);
      check($sformatf("rand%0d_code msg=%0h", i, m), 32'(code), 32'(exp_q.pop_front()));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'd9);
      if ($urandom_range(0, 1) == 1) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
